// File: rtl/conditional_unit.sv
`default_nettype none
// ============================================================================
//  Module      : conditional_unit
//  Description : Execute-stage condition check (AL/EQ) and NZCV flag merge
//                with a registered copy of the resulting flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module conditional_unit (
    input  logic       clk,
    input  logic       rst,
    input  logic       Cond,
    input  logic [3:0] Flags,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagsWrite,
    output logic       CondEx,
    output logic [3:0] FlagsNext,
    output logic [3:0] FlagsQ
);

    localparam int unsigned c_FLAG_Z = 2;

    logic       cond_ex_w;
    logic       write_nz_w;
    logic       write_cv_w;
    logic [3:0] flags_d;
    logic [3:0] flags_q;

    // AL always passes; EQ passes only when Z is set.
    always_comb begin
        cond_ex_w = 1'b1;
        if (Cond) begin
            cond_ex_w = Flags[c_FLAG_Z];
        end
    end

    assign write_nz_w = FlagsWrite[1] & cond_ex_w;
    assign write_cv_w = FlagsWrite[0] & cond_ex_w;

    // Unselected ALU groups are never routed, so X on them cannot leak out.
    always_comb begin
        flags_d      = Flags;
        if (write_nz_w) begin
            flags_d[3:2] = ALUFlags[3:2];
        end
        if (write_cv_w) begin
            flags_d[1:0] = ALUFlags[1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q <= 4'b0000;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign CondEx    = cond_ex_w;
    assign FlagsNext = flags_d;
    assign FlagsQ    = flags_q;

endmodule
`default_nettype wire

// File: tb/tb_conditional_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_conditional_unit
//  Description : Directed self-checking bench for conditional_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_conditional_unit;

    logic       clk;
    logic       rst;
    logic       Cond;
    logic [3:0] Flags;
    logic [3:0] ALUFlags;
    logic [1:0] FlagsWrite;
    logic       CondEx;
    logic [3:0] FlagsNext;
    logic [3:0] FlagsQ;

    int checks_q;
    int failures_q;

    conditional_unit u_dut (
        .clk        (clk),
        .rst        (rst),
        .Cond       (Cond),
        .Flags      (Flags),
        .ALUFlags   (ALUFlags),
        .FlagsWrite (FlagsWrite),
        .CondEx     (CondEx),
        .FlagsNext  (FlagsNext),
        .FlagsQ     (FlagsQ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks_q++;
        if (obs !== exp) begin
            failures_q++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic c, input logic [3:0] f, input logic [3:0] a,
                         input logic [1:0] w);
        Cond       = c;
        Flags      = f;
        ALUFlags   = a;
        FlagsWrite = w;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks_q   = 0;
        failures_q = 0;
        rst        = 1'b1;
        drive(1'b0, 4'b0000, 4'b0000, 2'b00);
        tick();
        tick();
        check_val("reset_flagsq", FlagsQ, 4'b0000);
        rst = 1'b0;

        // AL, full write, then registered
        drive(1'b0, 4'b0000, 4'b1100, 2'b11);
        check_val("al_condex", {3'b000, CondEx}, 4'b0001);
        check_val("al_next", FlagsNext, 4'b1100);
        tick();
        check_val("al_flagsq", FlagsQ, 4'b1100);

        // EQ taken
        drive(1'b1, 4'b0110, 4'b0011, 2'b11);
        check_val("eq1_condex", {3'b000, CondEx}, 4'b0001);
        check_val("eq1_next", FlagsNext, 4'b0011);
        drive(1'b1, 4'b0101, 4'b1100, 2'b11);
        check_val("eq2_condex", {3'b000, CondEx}, 4'b0001);
        check_val("eq2_next", FlagsNext, 4'b1100);

        // EQ not taken: N,C,V set but Z clear
        drive(1'b1, 4'b1011, 4'b0100, 2'b11);
        check_val("eqn_condex", {3'b000, CondEx}, 4'b0000);
        check_val("eqn_next", FlagsNext, 4'b1011);
        drive(1'b1, 4'b1011, 4'b0100, 2'b10);
        check_val("eqn_nz_next", FlagsNext, 4'b1011);

        // EQ taken, no write
        drive(1'b1, 4'b0100, 4'b1011, 2'b00);
        check_val("eq_nowr_condex", {3'b000, CondEx}, 4'b0001);
        check_val("eq_nowr_next", FlagsNext, 4'b0100);

        // Partial writes
        drive(1'b0, 4'b0101, 4'b1010, 2'b10);
        check_val("pw_nz", FlagsNext, 4'b1001);
        drive(1'b0, 4'b0101, 4'b1010, 2'b01);
        check_val("pw_cv", FlagsNext, 4'b0110);
        drive(1'b0, 4'b0101, 4'b1010, 2'b00);
        check_val("pw_none", FlagsNext, 4'b0101);

        // Unknowns on unselected ALU groups
        drive(1'b0, 4'b0101, 4'bxx10, 2'b01);
        check_val("x_nz_blocked", FlagsNext, 4'b0110);
        drive(1'b0, 4'b0101, 4'b10xx, 2'b10);
        check_val("x_cv_blocked", FlagsNext, 4'b1001);

        // Reset priority over capture
        drive(1'b0, 4'b0000, 4'b1111, 2'b11);
        tick();
        check_val("pre_rst_flagsq", FlagsQ, 4'b1111);
        drive(1'b0, 4'b0000, 4'b1100, 2'b11);
        rst = 1'b1;
        #1;
        check_val("rst_next_live", FlagsNext, 4'b1100);
        tick();
        check_val("rst_flagsq", FlagsQ, 4'b0000);
        rst = 1'b0;
        tick();
        check_val("post_rst_flagsq", FlagsQ, 4'b1100);

        // Feedback: FlagsQ driving Flags for an EQ instruction
        drive(1'b1, FlagsQ, 4'b0011, 2'b01);
        check_val("fb_condex", {3'b000, CondEx}, 4'b0001);
        tick();
        check_val("fb_flagsq", FlagsQ, 4'b1111);

        $display("TB_RESULT checks=%0d failures=%0d", checks_q, failures_q);
        $finish;
    end

endmodule
`default_nettype wire
